interp_outfifo: RTL and testbench
=================================

Name: interp_outfifo

Overview:
Output buffer that sits directly downstream of the nearest-neighbour interpolator. It captures each strobed output sample (o_ce/o_data of the interpolator, wired to i_ce/i_data here) into a small synchronous FIFO. It re-presents those samples on a valid/ready stream so a back-pressuring consumer (DAC formatter, bus master) can drain them. Dropped samples are flagged, never silently lost.

Parameters:
DW, 28, sample width in bits (matches interpolator INW)
LGFIFO, 4, log2 of FIFO depth; depth = 2^LGFIFO entries

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_ce  input  1  sample strobe from the interpolator; one sample per high cycle
i_data  input  DW  sample accompanying i_ce
o_valid  output  1  head-of-FIFO sample present on o_data
i_ready  input  1  consumer accepts o_data this cycle when o_valid high
o_data  output  DW  head-of-FIFO sample
o_fill  output  LGFIFO+1  number of entries currently stored (0..2^LGFIFO)
o_full  output  1  o_fill == 2^LGFIFO
o_overflow  output  1  sticky: a sample was dropped since last clear
i_clr_overflow  input  1  clears o_overflow

Behaviour:
- Clock/reset: one clock, i_clk. i_reset is synchronous, active-high, and has priority over all other inputs.
- Reset values: o_valid=0, o_fill=0, o_full=0, o_overflow=0. Read and write pointers are 0. FIFO memory is not reset.
- o_data is don't-care while o_valid=0.
- Pointers are LGFIFO+1 bits and wrap modulo 2^(LGFIFO+1). Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal.
- Read: rd = o_valid && i_ready.
- Write: wr = i_ce && (!o_full || rd). A write into a full FIFO is accepted only if a read occurs the same cycle.
- Drop: i_ce && o_full && !rd. The sample is discarded and o_overflow is set on the next edge.
- o_overflow clear: i_clr_overflow clears o_overflow on the next edge. If a drop occurs in the same cycle as i_clr_overflow, set wins and o_overflow stays 1.
- o_fill update: +1 on wr&&!rd, -1 on rd&&!wr, unchanged otherwise (including simultaneous wr&&rd). All status outputs are registered.
- Latency: a sample written at edge N into an empty FIFO gives o_valid=1 with that sample on o_data after edge N. This means it is visible the cycle after i_ce was high. There is no combinational path from i_ce to o_valid.
- First-word-fall-through: o_data always shows the oldest stored entry.
  - o_data and o_valid are stable while o_valid && !i_ready.
  - Order is strictly FIFO.
- Simultaneous read and write on an empty FIFO is impossible, because o_valid=0 means rd=0. The write simply lands.
- Simultaneous read and write with fill=1: the new sample appears on o_data after the edge. o_valid stays 1.
- i_ready is ignored while o_valid=0.
- Reset mid-operation flushes all contents. o_valid falls on the edge where i_reset is sampled high. i_ce during reset is ignored and does not set o_overflow.
- Target size: about 150 RTL lines (memory array, two pointers, fill counter, sticky flag).

Test Plan:
1. Reset, then i_ce one cycle with i_data=28'h0000123 and i_ready=1 -> o_valid=1 with o_data=28'h0000123 exactly one cycle after i_ce. o_valid=0 the cycle after that. o_fill goes 0→1→0.
2. i_ready=0, strobe 16 samples with values 1..16 (LGFIFO=4) -> o_fill=16, o_full=1, o_overflow=0. Then raise i_ready -> the bench reads 1..16 in order on consecutive cycles, and o_valid drops after the 16th.
3. Full FIFO, i_ready=0, one more i_ce with value 17 -> o_overflow=1 next cycle, o_fill stays 16, and the read-out sequence is still 1..16 with no 17.
4. Full FIFO, i_ready=1 and i_ce=1 with value 99 in the same cycle -> o_fill stays 16, o_overflow stays 0, and 99 is read out last.
5. o_overflow=1, pulse i_clr_overflow -> 0 next cycle. Repeat with i_clr_overflow coinciding with a drop -> o_overflow remains 1.
6. Fill to 5, then assert i_reset for one cycle while i_ce=1 -> o_valid=0, o_fill=0, o_overflow=0 after the edge. A subsequent sample 28'hABCDEF0 is the first one read out.

Source files
------------

// File: rtl/interp_outfifo.sv
// Output FIFO behind the nearest-neighbour interpolator: captures strobed samples and
// re-presents them first-word-fall-through on a valid/ready stream, flagging drops.
module interp_outfifo #(
  parameter int DW     = 28,
  parameter int LGFIFO = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ce,
  input  logic [DW-1:0]     i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DW-1:0]     o_data,
  output logic [LGFIFO:0]   o_fill,
  output logic              o_full,
  output logic              o_overflow,
  input  logic              i_clr_overflow
);

  localparam logic [LGFIFO:0] PTR_ONE = 1;
  localparam logic [LGFIFO:0] DEPTH   = PTR_ONE << LGFIFO;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   head_reg;
  logic [LGFIFO:0] wr_ptr_reg, wr_ptr_next;
  logic [LGFIFO:0] rd_ptr_reg, rd_ptr_next;
  logic [LGFIFO:0] fill_reg, fill_next;
  logic            valid_reg, valid_next;
  logic            full_reg, full_next;
  logic            overflow_reg, overflow_next;
  logic            rd, wr, drop, bypass;

  always_comb begin
    rd   = valid_reg && i_ready;
    wr   = i_ce && (!full_reg || rd);
    drop = i_ce && full_reg && !rd;

    wr_ptr_next = wr ? (wr_ptr_reg + PTR_ONE) : wr_ptr_reg;
    rd_ptr_next = rd ? (rd_ptr_reg + PTR_ONE) : rd_ptr_reg;

    fill_next = fill_reg;
    if (wr && !rd)
      fill_next = fill_reg + PTR_ONE;
    else if (rd && !wr)
      fill_next = fill_reg - PTR_ONE;

    valid_next = (wr_ptr_next != rd_ptr_next);
    full_next  = (wr_ptr_next[LGFIFO] != rd_ptr_next[LGFIFO]) &&
                 (wr_ptr_next[LGFIFO-1:0] == rd_ptr_next[LGFIFO-1:0]);

    // A drop in the same cycle as a clear keeps the flag set.
    overflow_next = overflow_reg;
    if (drop)
      overflow_next = 1'b1;
    else if (i_clr_overflow)
      overflow_next = 1'b0;

    // The incoming sample becomes the head directly when the FIFO would otherwise be empty.
    bypass = wr && (wr_ptr_reg[LGFIFO-1:0] == rd_ptr_next[LGFIFO-1:0]);
  end

  always_ff @(posedge i_clk) begin
    if (wr && !i_reset)
      mem[wr_ptr_reg[LGFIFO-1:0]] <= i_data;
  end

  // Registered head read, addressed by the next read pointer so o_data falls through.
  always_ff @(posedge i_clk) begin
    if (bypass)
      head_reg <= i_data;
    else
      head_reg <= mem[rd_ptr_next[LGFIFO-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      valid_reg    <= 1'b0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      fill_reg     <= fill_next;
      valid_reg    <= valid_next;
      full_reg     <= full_next;
      overflow_reg <= overflow_next;
    end
  end

  assign o_valid    = valid_reg;
  assign o_data     = head_reg;
  assign o_fill     = fill_reg;
  assign o_full     = full_reg;
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_interp_outfifo.sv
// Directed bench for interp_outfifo: latency, ordering, full/overflow corners and reset flush.
module tb_interp_outfifo;
  localparam int DW     = 28;
  localparam int LGFIFO = 4;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_ce;
  logic [DW-1:0]     i_data;
  logic              o_valid;
  logic              i_ready;
  logic [DW-1:0]     o_data;
  logic [LGFIFO:0]   o_fill;
  logic              o_full;
  logic              o_overflow;
  logic              i_clr_overflow;

  int checks   = 0;
  int failures = 0;

  interp_outfifo #(.DW(DW), .LGFIFO(LGFIFO)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_ce           (i_ce),
    .i_data         (i_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_fill         (o_fill),
    .o_full         (o_full),
    .o_overflow     (o_overflow),
    .i_clr_overflow (i_clr_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_seq(input int base, input int n);
    for (int k = 1; k <= n; k++) begin
      i_ce   = 1'b1;
      i_data = DW'(base + k);
      tick();
    end
    i_ce = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_ce = 1'b0; i_data = '0; i_ready = 1'b0; i_clr_overflow = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_fill", 32'(o_fill), 32'd0);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);

    // 1: single sample latency
    i_ce = 1'b1; i_data = 28'h0000123; i_ready = 1'b1;
    tick();
    i_ce = 1'b0;
    check("t1_valid", 32'(o_valid), 32'd1);
    check("t1_data", 32'(o_data), 32'h0000123);
    check("t1_fill1", 32'(o_fill), 32'd1);
    tick();
    check("t1_valid_off", 32'(o_valid), 32'd0);
    check("t1_fill0", 32'(o_fill), 32'd0);

    // 2: fill to 16
    i_ready = 1'b0;
    fill_seq(0, 16);
    check("t2_fill", 32'(o_fill), 32'd16);
    check("t2_full", 32'(o_full), 32'd1);
    check("t2_ovf", 32'(o_overflow), 32'd0);
    check("t2_head", 32'(o_data), 32'd1);

    // 3: drop into full FIFO
    i_ce = 1'b1; i_data = 28'd17;
    tick();
    i_ce = 1'b0;
    check("t3_ovf", 32'(o_overflow), 32'd1);
    check("t3_fill", 32'(o_fill), 32'd16);
    i_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check("t3_rd_valid", 32'(o_valid), 32'd1);
      check("t3_rd_data", 32'(o_data), 32'(k));
      tick();
    end
    check("t3_empty_valid", 32'(o_valid), 32'd0);
    check("t3_empty_fill", 32'(o_fill), 32'd0);
    check("t3_empty_full", 32'(o_full), 32'd0);

    // 5a: clear overflow
    i_clr_overflow = 1'b1;
    tick();
    i_clr_overflow = 1'b0;
    check("t5_clr", 32'(o_overflow), 32'd0);

    // 4: simultaneous read and write while full
    i_ready = 1'b0;
    fill_seq(100, 16);
    check("t4_full", 32'(o_full), 32'd1);
    check("t4_head", 32'(o_data), 32'd101);
    i_ready = 1'b1; i_ce = 1'b1; i_data = 28'd99;
    tick();
    i_ce = 1'b0; i_ready = 1'b0;
    check("t4_fill", 32'(o_fill), 32'd16);
    check("t4_ovf", 32'(o_overflow), 32'd0);
    check("t4_full2", 32'(o_full), 32'd1);
    check("t4_head2", 32'(o_data), 32'd102);
    tick();
    check("t4_stable_data", 32'(o_data), 32'd102);
    check("t4_stable_valid", 32'(o_valid), 32'd1);
    i_ready = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      check("t4_rd_valid", 32'(o_valid), 32'd1);
      check("t4_rd_data", 32'(o_data), (k == 17) ? 32'd99 : 32'(100 + k));
      tick();
    end
    check("t4_empty_valid", 32'(o_valid), 32'd0);

    // 5b: clear coinciding with drop keeps flag
    i_ready = 1'b0;
    fill_seq(200, 16);
    i_ce = 1'b1; i_data = 28'd300;
    tick();
    check("t5_set", 32'(o_overflow), 32'd1);
    i_clr_overflow = 1'b1;
    tick();
    i_ce = 1'b0;
    check("t5_set_wins", 32'(o_overflow), 32'd1);
    check("t5_fill", 32'(o_fill), 32'd16);
    tick();
    i_clr_overflow = 1'b0;
    check("t5_clr2", 32'(o_overflow), 32'd0);

    // 6: reset flush, with overflow set and i_ce high during reset
    i_ce = 1'b1; i_data = 28'd301;
    tick();
    check("t6_pre_ovf", 32'(o_overflow), 32'd1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0; i_ce = 1'b0;
    check("t6_valid", 32'(o_valid), 32'd0);
    check("t6_fill", 32'(o_fill), 32'd0);
    check("t6_ovf", 32'(o_overflow), 32'd0);
    check("t6_full", 32'(o_full), 32'd0);
    fill_seq(0, 5);
    check("t6_fill5", 32'(o_fill), 32'd5);
    i_reset = 1'b1; i_ce = 1'b1; i_data = 28'd55;
    tick();
    i_reset = 1'b0; i_ce = 1'b0;
    check("t6b_valid", 32'(o_valid), 32'd0);
    check("t6b_fill", 32'(o_fill), 32'd0);
    check("t6b_ovf", 32'(o_overflow), 32'd0);
    i_ce = 1'b1; i_data = 28'hABCDEF0; i_ready = 1'b1;
    tick();
    i_ce = 1'b0;
    check("t6_first_valid", 32'(o_valid), 32'd1);
    check("t6_first_data", 32'(o_data), 32'hABCDEF0);
    check("t6_first_fill", 32'(o_fill), 32'd1);
    tick();
    check("t6_drained", 32'(o_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
